// File: rtl/tpu_host_ctrl_if.sv
// rtl/tpu_host_ctrl_if.sv - job control, row streams and TPU MMIO bus bundle
interface tpu_host_ctrl_if #(
    parameter int ADDRW = 16,
    parameter int DATAW = 64
);
    logic             start;
    logic             busy;
    logic             done;
    logic [DATAW-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             mmio_r_w;
    logic [ADDRW-1:0] mmio_addr;
    logic [DATAW-1:0] mmio_wdata;
    logic [DATAW-1:0] mmio_rdata;

    modport slave (
        input  start, in_data, in_valid, out_ready, mmio_rdata,
        output busy, done, in_ready, out_data, out_valid, mmio_r_w, mmio_addr, mmio_wdata
    );

    modport master (
        output start, in_data, in_valid, out_ready, mmio_rdata,
        input  busy, done, in_ready, out_data, out_valid, mmio_r_w, mmio_addr, mmio_wdata
    );
endinterface

// File: rtl/tpu_host_ctrl.sv
// rtl/tpu_host_ctrl.sv - MMIO initiator running one TPU matmul job (load A/B, go, wait, read C)
module tpu_host_ctrl #(
    parameter int DIM         = 8,
    parameter int BITS_AB     = 8,
    parameter int BITS_C      = 16,
    parameter int ADDRW       = 16,
    parameter int DATAW       = 64,
    parameter int WAIT_CYCLES = 3*DIM-1
) (
    input  logic           clk,
    input  logic           rst_n,
    tpu_host_ctrl_if.slave bus
);
    localparam int C_WORDS = (DIM*BITS_C)/DATAW;
    localparam int NREAD   = DIM*C_WORDS;
    localparam int CW      = $clog2(DIM) + 1;
    localparam int KW      = $clog2(NREAD) + 1;
    localparam int WW      = $clog2(WAIT_CYCLES) + 1;

    localparam logic [DATAW-1:0] ROW_MASK = {DATAW{1'b1}} >> (DATAW - DIM*BITS_AB);
    localparam logic [ADDRW-1:0] BASE_A   = ADDRW'(16'h0100);
    localparam logic [ADDRW-1:0] BASE_B   = ADDRW'(16'h0200);
    localparam logic [ADDRW-1:0] BASE_C   = ADDRW'(16'h0300);
    localparam logic [ADDRW-1:0] ADDR_GO  = ADDRW'(16'h0400);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_GO, S_WAIT,
        S_RD_ISSUE, S_RD_CAPT, S_RD_HOLD, S_FIN
    } state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [KW-1:0]    r_k;
    logic [WW-1:0]    r_wcnt;
    logic             r_busy, r_done, r_out_valid, r_r_w;
    logic [DATAW-1:0] r_out_data, r_wdata;
    logic [ADDRW-1:0] r_addr;

    logic             w_load, w_accept, w_last_word, w_out_hs;
    logic [KW-1:0]    w_k_next;
    logic [ADDRW-1:0] w_row_off, w_k_off;

    assign w_load      = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign w_accept    = w_load && bus.in_valid;
    assign w_last_word = (r_cnt == CW'(DIM-1));
    // out_valid is always set while in RD_HOLD, so ready alone completes the handshake
    assign w_out_hs    = (r_state == S_RD_HOLD) && bus.out_ready;
    assign w_k_next    = (r_state == S_RD_HOLD) ? r_k + KW'(1) : '0;
    assign w_row_off   = {{(ADDRW-CW-3){1'b0}}, r_cnt, 3'b000};
    assign w_k_off     = {{(ADDRW-KW-3){1'b0}}, w_k_next, 3'b000};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (bus.start) w_next = S_LOAD_A;
            S_LOAD_A:   if (w_accept && w_last_word) w_next = S_LOAD_B;
            S_LOAD_B:   if (w_accept && w_last_word) w_next = S_GO;
            S_GO:       w_next = S_WAIT;
            // first WAIT cycle carries the GO write, so count WAIT_CYCLES idle cycles after it
            S_WAIT:     if (r_wcnt == WW'(WAIT_CYCLES)) w_next = S_RD_ISSUE;
            S_RD_ISSUE: w_next = S_RD_CAPT;
            S_RD_CAPT:  w_next = S_RD_HOLD;
            S_RD_HOLD:  if (w_out_hs) w_next = (r_k == KW'(NREAD-1)) ? S_FIN : S_RD_ISSUE;
            S_FIN:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_k         <= '0;
            r_wcnt      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_r_w       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE) && (w_next != S_FIN);
            r_done  <= (w_next == S_FIN);

            if (r_state == S_IDLE)
                r_cnt <= '0;
            else if (w_accept)
                r_cnt <= w_last_word ? '0 : r_cnt + CW'(1);

            r_wcnt <= (r_state == S_WAIT) ? r_wcnt + WW'(1) : '0;

            if (r_state == S_IDLE)
                r_k <= '0;
            else if (w_next == S_RD_ISSUE)
                r_k <= w_k_next;

            // bus returns to idle unless a cycle is scheduled for the next clock
            r_r_w   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            if (w_accept) begin
                r_r_w   <= 1'b1;
                r_addr  <= ((r_state == S_LOAD_A) ? BASE_A : BASE_B) + w_row_off;
                r_wdata <= bus.in_data & ROW_MASK;
            end else if (r_state == S_GO) begin
                r_r_w  <= 1'b1;
                r_addr <= ADDR_GO;
            end else if (w_next == S_RD_ISSUE) begin
                r_addr <= BASE_C + w_k_off;
            end

            if (r_state == S_RD_CAPT) begin
                r_out_data  <= bus.mmio_rdata;
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_load;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.mmio_r_w   = r_r_w;
    assign bus.mmio_addr  = r_addr;
    assign bus.mmio_wdata = r_wdata;
endmodule
